// File: rtl/fp_cvt_pkg.sv
// Shared types and constants for the RV32F integer/float conversion unit.
// Build option FP_CVT_SUBNORM_EN selects exact rounding of subnormal inputs (see fp_cvt_unit).
package fp_cvt_pkg;

  localparam logic [31:0] INT_MAX  = 32'h7FFF_FFFF;
  localparam logic [31:0] INT_MIN  = 32'h8000_0000;
  localparam logic [31:0] UINT_MAX = 32'hFFFF_FFFF;
  localparam logic [7:0]  BIAS     = 8'd127;

  typedef enum logic [2:0] {
    RM_RNE = 3'b000,
    RM_RTZ = 3'b001,
    RM_RDN = 3'b010,
    RM_RUP = 3'b011,
    RM_RMM = 3'b100,
    RM_DYN = 3'b111
  } rm_e;

  typedef enum logic [1:0] {
    OP_W_S  = 2'b00,
    OP_WU_S = 2'b01,
    OP_S_W  = 2'b10,
    OP_S_WU = 2'b11
  } op_e;

  typedef struct packed {
    logic nv;
    logic dz;
    logic of;
    logic uf;
    logic nx;
  } fflags_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_UNPACK,
    ST_ALIGN,
    ST_ROUND,
    ST_DONE
  } state_e;

  // Increment decision for a sign-magnitude value given lsb, guard and sticky.
  function automatic logic rnd_up(input logic [2:0] rm, input logic sign,
                                  input logic lsb, input logic g, input logic s);
    logic up;
    up = 1'b0;
    case (rm)
      RM_RNE:  up = g & (s | lsb);
      RM_RDN:  up = sign & (g | s);
      RM_RUP:  up = ~sign & (g | s);
      RM_RMM:  up = g;
      default: up = 1'b0;
    endcase
    return up;
  endfunction

endpackage

// File: rtl/fp_lzc32.sv
// Combinational 32-bit leading-zero counter; all-zero input yields 32.
module fp_lzc32 (
  input  logic [31:0] i_data,
  output logic [5:0]  o_cnt
);
  // Ascending scan: the highest set bit is the last one to write.
  always_comb begin
    o_cnt = 6'd32;
    for (int i = 0; i < 32; i++) begin
      if (i_data[i]) o_cnt = 6'(31 - i);
    end
  end
endmodule

// File: rtl/fp_cvt_unit.sv
// Multi-cycle FCVT.{W,WU}.S / FCVT.S.{W,WU} unit, one op in flight, valid/ready on both sides.
// Define FP_CVT_SUBNORM_EN to round subnormal inputs exactly instead of flushing them to zero.
module fp_cvt_unit
  import fp_cvt_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int FLEN = 32
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic            i_valid,
  output logic            o_ready,
  input  logic [1:0]      i_op,
  input  logic [2:0]      i_rm,
  input  logic [2:0]      i_frm,
  input  logic [XLEN-1:0] i_operand,
  input  logic            i_flush,
  output logic            o_valid,
  input  logic            i_ready,
  output logic [XLEN-1:0] o_result,
  output logic [4:0]      o_fflags,
  output logic            o_illegal
);

`ifdef FP_CVT_SUBNORM_EN
  localparam logic SUBNORM_EN = 1'b1;
`else
  localparam logic SUBNORM_EN = 1'b0;
`endif

  state_e      r_state, w_next;
  logic [1:0]  r_op;
  logic [2:0]  r_rm;
  logic        r_ill;
  logic [31:0] r_opnd;
  logic        r_sign, r_nan, r_tiny, r_zero, r_big, r_g, r_s;
  logic [7:0]  r_exp, r_fexp;
  logic [31:0] r_mag, r_int;
  logic [5:0]  r_lz;
  logic [31:0] r_result;
  fflags_t     r_fflags;
  logic        r_illegal;

  logic        w_acc, w_f2i;
  logic [2:0]  w_rm_eff;
  logic [7:0]  w_f_exp;
  logic [22:0] w_f_man;
  logic        w_i_neg;
  logic [31:0] w_i_mag;
  logic [5:0]  w_lz;
  logic [5:0]  w_shamt;
  logic [63:0] w_fix;
  logic [31:0] w_norm;
  logic        w_inexact, w_up;
  logic [32:0] w_mag33;
  logic [23:0] w_man24;
  logic [7:0]  w_exp_rnd;
  logic [FLEN-1:0] w_fres;
  logic [31:0] w_res;
  fflags_t     w_fl;

  assign o_ready   = (r_state == ST_IDLE);
  assign o_valid   = (r_state == ST_DONE);
  assign o_result  = r_result;
  assign o_fflags  = r_fflags;
  assign o_illegal = r_illegal;

  assign w_acc    = (r_state == ST_IDLE) && i_valid && !i_flush;
  assign w_rm_eff = (i_rm == RM_DYN) ? i_frm : i_rm;
  assign w_f2i    = ~r_op[1];

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= ST_IDLE;
    else          r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:   if (i_valid) w_next = ST_UNPACK;
      ST_UNPACK: w_next = ST_ALIGN;
      ST_ALIGN:  w_next = ST_ROUND;
      ST_ROUND:  w_next = ST_DONE;
      ST_DONE:   if (i_ready) w_next = ST_IDLE;
      default:   w_next = ST_IDLE;
    endcase
    if (i_flush) w_next = ST_IDLE;
  end

  // Unpack: float fields, and sign/magnitude + leading zeros for the integer path.
  assign w_f_exp = r_opnd[30:23];
  assign w_f_man = r_opnd[22:0];
  assign w_i_neg = (r_op == OP_S_W) && r_opnd[31];
  assign w_i_mag = w_i_neg ? (32'd0 - r_opnd) : r_opnd;

  fp_lzc32 u_lzc (
    .i_data (w_i_mag),
    .o_cnt  (w_lz)
  );

  // Align: the float is placed as 32.32 fixed point; exponents 118..158 fit without loss of sticky.
  assign w_shamt = 6'(r_exp - (BIAS - 8'd9));
  assign w_fix   = {32'd0, r_mag} << w_shamt;
  assign w_norm  = r_mag << r_lz;

  // Round
  assign w_inexact = r_g | r_s;
  assign w_up      = rnd_up(r_rm, r_sign, r_int[0], r_g, r_s);
  assign w_mag33   = {1'b0, r_int} + 33'(w_up);
  assign w_man24   = {1'b0, r_int[22:0]} + 24'(w_up);
  assign w_exp_rnd = r_fexp + 8'(w_man24[23]);
  assign w_fres    = r_zero ? '0 : {r_sign, w_exp_rnd, w_man24[22:0]};

  always_comb begin
    w_res = '0;
    w_fl  = '0;
    case (r_op)
      OP_W_S: begin
        if (r_nan) begin
          w_res = INT_MAX; w_fl.nv = 1'b1;
        end else if (r_big) begin
          w_res = r_sign ? INT_MIN : INT_MAX; w_fl.nv = 1'b1;
        end else if (!r_sign) begin
          if (w_mag33 > 33'h0_7FFF_FFFF) begin
            w_res = INT_MAX; w_fl.nv = 1'b1;
          end else begin
            w_res = w_mag33[31:0]; w_fl.nx = w_inexact;
          end
        end else begin
          if (w_mag33 > 33'h0_8000_0000) begin
            w_res = INT_MIN; w_fl.nv = 1'b1;
          end else begin
            w_res = 32'd0 - w_mag33[31:0]; w_fl.nx = w_inexact;
          end
        end
      end
      OP_WU_S: begin
        if (r_nan) begin
          w_res = UINT_MAX; w_fl.nv = 1'b1;
        end else if (r_big) begin
          w_res = r_sign ? 32'd0 : UINT_MAX; w_fl.nv = 1'b1;
        end else if (!r_sign) begin
          if (w_mag33[32]) begin
            w_res = UINT_MAX; w_fl.nv = 1'b1;
          end else begin
            w_res = w_mag33[31:0]; w_fl.nx = w_inexact;
          end
        end else begin
          // Negative inputs only survive when they round to zero.
          w_res = 32'd0;
          if (w_mag33 != 33'd0) w_fl.nv = 1'b1;
          else                  w_fl.nx = w_inexact;
        end
      end
      default: begin
        w_res   = w_fres;
        w_fl.nx = w_inexact;
      end
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_op      <= '0;
      r_rm      <= '0;
      r_ill     <= 1'b0;
      r_opnd    <= '0;
      r_sign    <= 1'b0;
      r_nan     <= 1'b0;
      r_tiny    <= 1'b0;
      r_zero    <= 1'b0;
      r_big     <= 1'b0;
      r_g       <= 1'b0;
      r_s       <= 1'b0;
      r_exp     <= '0;
      r_fexp    <= '0;
      r_mag     <= '0;
      r_int     <= '0;
      r_lz      <= '0;
      r_result  <= '0;
      r_fflags  <= '0;
      r_illegal <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: if (w_acc) begin
          r_op   <= i_op;
          r_rm   <= w_rm_eff;
          r_ill  <= (w_rm_eff == 3'b101) || (w_rm_eff == 3'b110) || (w_rm_eff == 3'b111);
          r_opnd <= i_operand;
        end
        ST_UNPACK: begin
          r_exp <= w_f_exp;
          r_lz  <= w_lz;
          if (w_f2i) begin
            r_sign <= r_opnd[31];
            r_nan  <= (w_f_exp == 8'hFF) && (w_f_man != 23'd0);
            r_tiny <= SUBNORM_EN && (w_f_exp == 8'd0) && (w_f_man != 23'd0);
            r_mag  <= (w_f_exp == 8'd0) ? 32'd0 : {8'd0, 1'b1, w_f_man};
          end else begin
            r_sign <= w_i_neg;
            r_nan  <= 1'b0;
            r_tiny <= 1'b0;
            r_mag  <= w_i_mag;
          end
        end
        ST_ALIGN: begin
          if (w_f2i) begin
            r_zero <= 1'b0;
            r_fexp <= '0;
            r_big  <= (r_exp >= BIAS + 8'd32);
            if (r_exp >= BIAS + 8'd32) begin
              r_int <= '0; r_g <= 1'b0; r_s <= 1'b0;
            end else if (r_exp >= BIAS - 8'd9) begin
              r_int <= w_fix[63:32];
              r_g   <= w_fix[31];
              r_s   <= |w_fix[30:0];
            end else begin
              // Below 2^-9 (or subnormal): only sticky can be set.
              r_int <= '0;
              r_g   <= 1'b0;
              r_s   <= (r_mag != 32'd0) || r_tiny;
            end
          end else begin
            r_big  <= 1'b0;
            r_zero <= (r_mag == 32'd0);
            r_int  <= {8'd0, w_norm[31:8]};
            r_g    <= w_norm[7];
            r_s    <= |w_norm[6:0];
            r_fexp <= BIAS + 8'd31 - {2'b00, r_lz};
          end
        end
        ST_ROUND: begin
          r_result  <= r_ill ? 32'd0 : w_res;
          r_fflags  <= r_ill ? '0 : w_fl;
          r_illegal <= r_ill;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fp_cvt_unit.sv
// Self-checking bench for fp_cvt_unit: real-arithmetic reference model, scoreboard, directed + random ops.
module tb_fp_cvt_unit;

  logic        i_clk = 1'b0;
  logic        i_rst_n;
  logic        i_valid, i_flush, i_ready;
  logic [1:0]  i_op;
  logic [2:0]  i_rm, i_frm;
  logic [31:0] i_operand;
  logic        o_ready, o_valid, o_illegal;
  logic [31:0] o_result;
  logic [4:0]  o_fflags;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [31:0] res;
    logic [4:0]  fl;
    logic        ill;
  } exp_t;
  exp_t q[$];

  fp_cvt_unit dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_valid(i_valid), .o_ready(o_ready),
    .i_op(i_op), .i_rm(i_rm), .i_frm(i_frm), .i_operand(i_operand),
    .i_flush(i_flush), .o_valid(o_valid), .i_ready(i_ready),
    .o_result(o_result), .o_fflags(o_fflags), .o_illegal(o_illegal)
  );

  always #5 i_clk = ~i_clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%h exp=%h", nm, act, exp);
    end
  endtask

  function automatic real pow2(input int e);
    real p;
    p = 1.0;
    if (e >= 0) repeat (e) p = p * 2.0;
    else        repeat (-e) p = p / 2.0;
    return p;
  endfunction

  function automatic real rnd_real(input real v, input logic [2:0] rm);
    real fl, fr;
    fl = $floor(v);
    fr = v - fl;
    case (rm)
      3'd0: begin
        if (fr > 0.5)      return fl + 1.0;
        else if (fr < 0.5) return fl;
        else               return ($floor(fl / 2.0) * 2.0 == fl) ? fl : fl + 1.0;
      end
      3'd1:    return (v >= 0.0) ? fl : $ceil(v);
      3'd2:    return fl;
      3'd3:    return $ceil(v);
      default: return (v >= 0.0) ? $floor(v + 0.5) : -$floor(-v + 0.5);
    endcase
  endfunction

  // Reference: float->int via exact real arithmetic, int->float via integer quotient/remainder.
  task automatic model(input logic [1:0] op, input logic [2:0] rm, input logic [2:0] frm,
                       input logic [31:0] x, output exp_t e);
    logic [2:0] eff;
    eff = (rm == 3'b111) ? frm : rm;
    e.res = 32'd0; e.fl = 5'd0; e.ill = 1'b0;
    if (eff >= 3'd5) begin
      e.ill = 1'b1;
    end else if (op < 2'd2) begin
      logic [7:0] ex;
      logic [22:0] mn;
      real v, r;
      ex = x[30:23]; mn = x[22:0];
      if (ex == 8'hFF && mn != 0) begin
        e.res = (op == 2'd0) ? 32'h7FFF_FFFF : 32'hFFFF_FFFF;
        e.fl  = 5'h10;
      end else begin
        if (ex == 8'hFF) v = 1.0e40;
`ifdef FP_CVT_SUBNORM_EN
        else if (ex == 8'd0) v = real'(mn) * pow2(-149);
`else
        else if (ex == 8'd0) v = 0.0;
`endif
        else v = (8388608.0 + real'(mn)) * pow2(int'(ex) - 150);
        if (x[31]) v = -v;
        r = rnd_real(v, eff);
        if (op == 2'd0) begin
          if (r > 2147483647.0)       begin e.res = 32'h7FFF_FFFF; e.fl = 5'h10; end
          else if (r < -2147483648.0) begin e.res = 32'h8000_0000; e.fl = 5'h10; end
          else begin e.res = 32'(longint'(r)); e.fl = (r != v) ? 5'h01 : 5'h00; end
        end else begin
          if (r > 4294967295.0) begin e.res = 32'hFFFF_FFFF; e.fl = 5'h10; end
          else if (r < 0.0)     begin e.res = 32'h0;         e.fl = 5'h10; end
          else begin e.res = 32'(longint'(r)); e.fl = (r != v) ? 5'h01 : 5'h00; end
        end
      end
    end else begin
      logic sgn, up;
      longint m, qq, rem, half;
      int k, ebias;
      sgn = (op == 2'd2) && x[31];
      m = (op == 2'd2) ? longint'($signed(x)) : longint'({32'd0, x});
      if (m < 0) m = -m;
      if (m != 0) begin
        k = 0;
        while ((m >>> k) >= 64'd16777216) k++;
        qq = m >>> k;
        rem = m - (qq <<< k);
        half = (k > 0) ? (64'd1 <<< (k - 1)) : 64'd0;
        ebias = 150 + k;
        while (qq < 64'd8388608) begin qq = qq <<< 1; ebias--; end
        case (eff)
          3'd0:    up = (rem > half) || (k > 0 && rem == half && qq[0]);
          3'd2:    up = sgn && rem != 0;
          3'd3:    up = !sgn && rem != 0;
          3'd4:    up = (k > 0) && (rem >= half);
          default: up = 1'b0;
        endcase
        qq = qq + longint'(up);
        if (qq == 64'd16777216) begin qq = 64'd8388608; ebias++; end
        e.res = {sgn, 8'(ebias), qq[22:0]};
        e.fl  = (rem != 0) ? 5'h01 : 5'h00;
      end
    end
  endtask

  // Scoreboard compare on every cycle a result is presented.
  always @(negedge i_clk) begin
    if (i_rst_n && o_valid) begin
      if (q.size() == 0) chk("spurious_valid", 64'(o_valid), 64'd0);
      else begin
        chk("sb_result", 64'(o_result), 64'(q[0].res));
        chk("sb_fflags", 64'(o_fflags), 64'(q[0].fl));
        chk("sb_illegal", 64'(o_illegal), 64'(q[0].ill));
        chk("sb_ready_low", 64'(o_ready), 64'd0);
        if (i_ready) void'(q.pop_front());
      end
    end
  end

  task automatic issue(input logic [1:0] op, input logic [2:0] rm, input logic [2:0] frm,
                       input logic [31:0] x, input int hold, input logic chg_frm,
                       output exp_t m, output exp_t d);
    int cnt;
    model(op, rm, frm, x, m);
    q.push_back(m);
    i_op = op; i_rm = rm; i_frm = frm; i_operand = x; i_valid = 1'b1;
    cnt = 0;
    while (!o_ready && cnt < 20) begin @(posedge i_clk); #1; cnt++; end
    chk("ready_before_accept", 64'(o_ready), 64'd1);
    @(posedge i_clk); #1;
    i_valid = 1'b0; i_operand = $urandom; i_op = 2'($urandom);
    if (chg_frm) i_frm = 3'b000;
    cnt = 0;
    while (!o_valid && cnt < 20) begin @(posedge i_clk); #1; cnt++; end
    chk("latency", 64'(cnt), 64'd3);
    d.res = o_result; d.fl = o_fflags; d.ill = o_illegal;
    repeat (hold) begin
      @(posedge i_clk); #1;
      chk("hold_valid", 64'(o_valid), 64'd1);
    end
    i_ready = 1'b1;
    @(posedge i_clk); #1;
    i_ready = 1'b0;
    chk("post_hs_valid", 64'(o_valid), 64'd0);
    chk("post_hs_ready", 64'(o_ready), 64'd1);
  endtask

  task automatic dir(input string nm, input logic [1:0] op, input logic [2:0] rm,
                     input logic [2:0] frm, input logic [31:0] x, input logic [31:0] eres,
                     input logic [4:0] efl, input logic eill, input int hold, input logic chg);
    exp_t m, d;
    issue(op, rm, frm, x, hold, chg, m, d);
    chk({"model_", nm}, {27'd0, m.ill, m.fl, m.res}, {27'd0, eill, efl, eres});
    chk({"dut_", nm},   {27'd0, d.ill, d.fl, d.res}, {27'd0, eill, efl, eres});
  endtask

  function automatic logic [31:0] gen_float();
    logic [7:0] ex;
    logic [22:0] mn;
    int p;
    p = $urandom_range(0, 15);
    mn = 23'($urandom);
    if (p == 0)      ex = 8'hFF;
    else if (p == 1) ex = 8'h00;
    else if (p == 2) ex = 8'($urandom_range(156, 160));
    else             ex = 8'($urandom_range(112, 160));
    if ($urandom_range(0, 3) == 0) mn = mn & ~((23'd1 << $urandom_range(0, 22)) - 23'd1);
    if ($urandom_range(0, 7) == 0) mn = 23'd0;
    return {1'($urandom), ex, mn};
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog act=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t m, d;
    i_rst_n = 1'b0; i_valid = 1'b0; i_flush = 1'b0; i_ready = 1'b0;
    i_op = '0; i_rm = '0; i_frm = '0; i_operand = '0;
    #12;
    chk("rst_valid", 64'(o_valid), 64'd0);
    chk("rst_ready", 64'(o_ready), 64'd1);
    chk("rst_result", 64'(o_result), 64'd0);
    chk("rst_fflags", 64'(o_fflags), 64'd0);
    chk("rst_illegal", 64'(o_illegal), 64'd0);
    @(negedge i_clk); i_rst_n = 1'b1;
    @(posedge i_clk); #1;

    dir("ws_1p5_rne", 2'd0, 3'd0, 3'd0, 32'h3FC0_0000, 32'h0000_0002, 5'h01, 1'b0, 0, 1'b0);
    dir("ws_1p5_rtz", 2'd0, 3'd1, 3'd0, 32'h3FC0_0000, 32'h0000_0001, 5'h01, 1'b0, 0, 1'b0);
    dir("ws_nan",     2'd0, 3'd0, 3'd0, 32'h7FC0_0000, 32'h7FFF_FFFF, 5'h10, 1'b0, 0, 1'b0);
    dir("wus_m1",     2'd1, 3'd0, 3'd0, 32'hBF80_0000, 32'h0000_0000, 5'h10, 1'b0, 0, 1'b0);
    dir("wus_m0p3",   2'd1, 3'd0, 3'd0, 32'hBE99_999A, 32'h0000_0000, 5'h01, 1'b0, 0, 1'b0);
    dir("sw_2p24_rne", 2'd2, 3'd0, 3'd0, 32'h0100_0001, 32'h4B80_0000, 5'h01, 1'b0, 0, 1'b0);
    dir("sw_2p24_rup", 2'd2, 3'd3, 3'd0, 32'h0100_0001, 32'h4B80_0001, 5'h01, 1'b0, 0, 1'b0);
    dir("sw_intmin",  2'd2, 3'd0, 3'd0, 32'h8000_0000, 32'hCF00_0000, 5'h00, 1'b0, 0, 1'b0);
    dir("swu_max",    2'd3, 3'd0, 3'd0, 32'hFFFF_FFFF, 32'h4F80_0000, 5'h01, 1'b0, 0, 1'b0);
    dir("sw_zero",    2'd2, 3'd2, 3'd0, 32'h0000_0000, 32'h0000_0000, 5'h00, 1'b0, 0, 1'b0);
    dir("dyn_rdn",    2'd0, 3'd7, 3'd2, 32'hBFC0_0000, 32'hFFFF_FFFE, 5'h01, 1'b0, 0, 1'b1);
    dir("rm_101",     2'd0, 3'd5, 3'd0, 32'h3FC0_0000, 32'h0000_0000, 5'h00, 1'b1, 0, 1'b0);
    dir("dyn_frm111", 2'd2, 3'd7, 3'd7, 32'h0000_0005, 32'h0000_0000, 5'h00, 1'b1, 0, 1'b0);
    dir("ws_negzero", 2'd0, 3'd0, 3'd0, 32'h8000_0000, 32'h0000_0000, 5'h00, 1'b0, 0, 1'b0);
    dir("ws_2p31",    2'd0, 3'd0, 3'd0, 32'h4F00_0000, 32'h7FFF_FFFF, 5'h10, 1'b0, 0, 1'b0);
    dir("ws_m2p31",   2'd0, 3'd0, 3'd0, 32'hCF00_0000, 32'h8000_0000, 5'h00, 1'b0, 0, 1'b0);
    dir("wus_2p32",   2'd1, 3'd0, 3'd0, 32'h4F80_0000, 32'hFFFF_FFFF, 5'h10, 1'b0, 0, 1'b0);
    dir("ws_minf",    2'd0, 3'd0, 3'd0, 32'hFF80_0000, 32'h8000_0000, 5'h10, 1'b0, 0, 1'b0);
    dir("ws_2p5_rmm", 2'd0, 3'd4, 3'd0, 32'h4020_0000, 32'h0000_0003, 5'h01, 1'b0, 0, 1'b0);
`ifdef FP_CVT_SUBNORM_EN
    dir("ws_sub_rup",  2'd0, 3'd3, 3'd0, 32'h0000_0001, 32'h0000_0001, 5'h01, 1'b0, 0, 1'b0);
    dir("wus_msub_rdn", 2'd1, 3'd2, 3'd0, 32'h8000_0001, 32'h0000_0000, 5'h10, 1'b0, 0, 1'b0);
`else
    dir("ws_sub_rup",  2'd0, 3'd3, 3'd0, 32'h0000_0001, 32'h0000_0000, 5'h00, 1'b0, 0, 1'b0);
    dir("wus_msub_rdn", 2'd1, 3'd2, 3'd0, 32'h8000_0001, 32'h0000_0000, 5'h00, 1'b0, 0, 1'b0);
`endif
    // Backpressure: hold 5 cycles, then an immediate follow-on request.
    dir("hold5",      2'd2, 3'd0, 3'd0, 32'h0000_0003, 32'h4040_0000, 5'h00, 1'b0, 5, 1'b0);
    dir("b2b",        2'd3, 3'd1, 3'd0, 32'h0000_0007, 32'h40E0_0000, 5'h00, 1'b0, 0, 1'b0);

    // Flush while in ALIGN.
    i_op = 2'd0; i_rm = 3'd0; i_operand = 32'h3FC0_0000; i_valid = 1'b1;
    @(posedge i_clk); #1; i_valid = 1'b0;
    @(posedge i_clk); #1; i_flush = 1'b1;
    @(posedge i_clk); #1; i_flush = 1'b0;
    chk("flush_ready", 64'(o_ready), 64'd1);
    repeat (5) begin
      chk("flush_no_valid", 64'(o_valid), 64'd0);
      @(posedge i_clk); #1;
    end
    // Flush together with a request in IDLE: not accepted.
    i_valid = 1'b1; i_flush = 1'b1;
    @(posedge i_clk); #1;
    i_valid = 1'b0; i_flush = 1'b0;
    chk("flush_idle_ready", 64'(o_ready), 64'd1);

    // Reset while a result is being presented.
    i_op = 2'd2; i_rm = 3'd0; i_operand = 32'h0000_0009; i_valid = 1'b1;
    @(posedge i_clk); #1; i_valid = 1'b0;
    repeat (3) @(posedge i_clk);
    #1;
    chk("pre_rst_valid", 64'(o_valid), 64'd1);
    i_rst_n = 1'b0; #1;
    chk("mid_rst_valid", 64'(o_valid), 64'd0);
    chk("mid_rst_ready", 64'(o_ready), 64'd1);
    chk("mid_rst_result", 64'(o_result), 64'd0);
    chk("mid_rst_fflags", 64'(o_fflags), 64'd0);
    chk("mid_rst_illegal", 64'(o_illegal), 64'd0);
    @(negedge i_clk); i_rst_n = 1'b1;
    @(posedge i_clk); #1;

    for (int n = 0; n < 250; n++) begin
      logic [1:0] op;
      logic [2:0] rm, frm;
      logic [31:0] x;
      int p;
      op = 2'($urandom);
      p = $urandom_range(0, 9);
      frm = 3'($urandom_range(0, 4));
      if (p <= 4)      rm = 3'(p);
      else if (p <= 6) rm = 3'b111;
      else if (p == 7) begin rm = 3'b111; frm = 3'($urandom_range(0, 7)); end
      else if (p == 8) rm = 3'b101;
      else             rm = 3'b110;
      if (op < 2'd2) x = gen_float();
      else           x = $urandom >> $urandom_range(0, 31);
      if (op == 2'd2 && $urandom_range(0, 1) == 1) x = 32'd0 - x;
      issue(op, rm, frm, x, $urandom_range(0, 3), 1'($urandom_range(0, 1)), m, d);
    end

    repeat (3) @(posedge i_clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fp_cvt_unit.md
Name: fp_cvt_unit

Overview:
- Multi-cycle RV32F conversion unit: FCVT.W.S, FCVT.WU.S, FCVT.S.W, FCVT.S.WU.
- Sits beside the FP CSR block, which supplies the dynamic rounding mode (frm). This unit produces the 5-bit exception flags that writeback ORs into fflags.
- Uses a valid/ready handshake on both sides, with one operation in flight at a time.

Parameters:
- XLEN, 32, integer width. Only 32 is supported.
- FLEN, 32, float width. Only 32 (binary32) is supported.

Ports:
- i_clk  in  1  clock
- i_rst_n  in  1  reset, asynchronous, active-low
- i_valid  in  1  request valid
- o_ready  out  1  unit can accept a request
- i_op  in  2  00 W.S, 01 WU.S, 10 S.W, 11 S.WU
- i_rm  in  3  instruction rm field; 111 = dynamic
- i_frm  in  3  current frm from the CSR block
- i_operand  in  32  float bits or integer
- i_flush  in  1  kill the in-flight op
- o_valid  out  1  result valid
- i_ready  in  1  consumer accepts the result
- o_result  out  32  converted value
- o_fflags  out  5  {nv,dz,of,uf,nx}; dz/of/uf are always 0
- o_illegal  out  1  rm invalid; qualified by o_valid

Behaviour:
- Reset values:
  - o_valid=0, o_ready=1, o_result=0, o_fflags=0, o_illegal=0.
  - FSM in IDLE.
- FSM states: IDLE → UNPACK → ALIGN → ROUND → DONE → IDLE.
  - IDLE: o_ready=1. Accept when i_valid&&o_ready&&!i_flush. Capture op, operand and effective rm.
  - UNPACK: classify the input (NaN, inf, zero, subnormal, normal). Compute sign and magnitude; run the leading-zero count for int→float.
  - ALIGN: shift the mantissa or integer; form guard and sticky bits.
  - ROUND: apply rounding, saturation and flags; register the outputs.
  - DONE: o_valid=1. Hold o_result, o_fflags and o_illegal stable until i_valid... specifically until i_ready; go to IDLE on the edge where o_valid&&i_ready.
- Latency: accepted at edge E0 → o_valid high after edge E3. Throughput is at most one op per 5 cycles.
- o_ready=1 only in IDLE.
- Effective rm:
  - rm = i_rm, or i_frm if i_rm==111. Captured at accept; later i_frm changes are ignored.
  - rm ∈ {101,110}, or dynamic with i_frm ∈ {101,110,111}: o_illegal=1, o_result=0, o_fflags=0, same latency.
- Rounding modes: RNE 000, RTZ 001, RDN 010, RUP 011, RMM 100.
- W.S:
  - NaN or +inf or rounded value > 2^31−1 → 0x7FFFFFFF, NV.
  - −inf or rounded value < −2^31 → 0x80000000, NV.
  - Otherwise NX if inexact.
- WU.S:
  - NaN or +inf or rounded value > 2^32−1 → 0xFFFFFFFF, NV.
  - −inf or negative input whose rounded value is nonzero → 0, NV.
  - Negative input rounding to 0 → 0, NX only.
- When NV is set, NX is never set.
- S.W / S.WU:
  - Exact for |x| ≤ 2^24; otherwise round, NX if any discarded bit is nonzero.
  - 0 → +0.0 (0x00000000).
  - Overflow is impossible.
- ±0.0 input to W.S/WU.S → 0, no flags.
- Flush:
  - i_flush in any state → IDLE on the next edge; o_valid=0; the result is discarded.
  - i_flush with i_valid in IDLE: flush wins, request not accepted.
- Reset mid-operation returns immediately to the reset values.

Optional Feature:
- Macro: FP_CVT_SUBNORM_EN.
- Defined: subnormal inputs to W.S/WU.S are rounded exactly.
  - Result is 0 or ±1 depending on rm and sign; NX set.
  - WU.S with a negative subnormal rounding to −1 → 0, NV.
- Undefined: subnormal inputs are flushed to signed zero before rounding. Result 0, no flags.

Decomposition:
- Package fp_cvt_pkg:
  - rm enum (RNE, RTZ, RDN, RUP, RMM, DYN).
  - op enum.
  - fflags packed struct {nv,dz,of,uf,nx}, matching CSR bit order.
  - Constants: INT_MAX 0x7FFFFFFF, INT_MIN 0x80000000, UINT_MAX 0xFFFFFFFF, BIAS 127.
  - FSM state enum.
- One sub-module, fp_lzc32: a combinational 32-bit leading-zero counter, used in UNPACK.

Test Plan:
- W.S 0x3FC00000 (1.5): RNE → 0x00000002, fflags 0x01; RTZ → 0x00000001, fflags 0x01.
- W.S 0x7FC00000 → 0x7FFFFFFF, fflags 0x10. WU.S 0xBF800000 → 0x00000000, fflags 0x10. WU.S 0xBE99999A RNE → 0, fflags 0x01.
- S.W 0x01000001: RNE → 0x4B800000, 0x01; RUP → 0x4B800001, 0x01. S.W 0x80000000 → 0xCF000000, 0x00. S.WU 0xFFFFFFFF RNE → 0x4F800000, 0x01.
- i_rm=111, i_frm=010, W.S 0xBFC00000 → 0xFFFFFFFE, 0x01. Change i_frm to 000 after accept → result unchanged. i_rm=101 → o_illegal=1, result 0, flags 0.
- Hold i_ready=0 for 5 cycles after o_valid: outputs stable, o_ready=0. o_valid drops and o_ready rises the edge after the handshake. Back-to-back request accepted in the following cycle.
- Assert i_flush in the ALIGN state: no o_valid pulse; o_ready=1 next cycle. Asserting i_rst_n low mid-op returns all outputs to their reset values.
